cpu_run_ctrl: RTL

Run controller for the single-cycle RISC-V core. It sequences the core through reset, free-running execution, single-step and halt by driving the core's reset and a clock-enable for every architectural state element (PC register, register file, data RAM). It watches the fetched PC and instruction to stop on breakpoints, explicit halt requests or program-terminating instructions, and counts retired instructions. It sits between the testbench/host controls and the top-level core.

---
 rtl/cpu_run_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/cpu_run_ctrl.sv
// Run controller for the single-cycle core: reset, run, step and halt
// sequencing, stop detection and retired-instruction counting.
module cpu_run_ctrl #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int RST_CYCLES    = 4,
  parameter int CNT_WIDTH     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     resume,
  input  logic                     step,
  input  logic                     halt_req,
  input  logic                     bp_en,
  input  logic [ADDRESS_WIDTH-1:0] bp_addr,
  input  logic [ADDRESS_WIDTH-1:0] pc,
  input  logic [DATA_WIDTH-1:0]    instr,
  output logic                     cpu_rst,
  output logic                     cpu_en,
  output logic [2:0]               state,
  output logic                     halted,
  output logic [1:0]               halt_cause,
  output logic [CNT_WIDTH-1:0]     instret
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RESET = 3'd1,
    S_RUN   = 3'd2,
    S_STEP  = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam int RCW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [RCW-1:0] RLOAD = RCW'(RST_CYCLES - 1);

  localparam logic [DATA_WIDTH-1:0] I_ECALL  = DATA_WIDTH'(32'h0000_0073);
  localparam logic [DATA_WIDTH-1:0] I_EBREAK = DATA_WIDTH'(32'h0010_0073);
  localparam logic [DATA_WIDTH-1:0] I_SELFJ  = DATA_WIDTH'(32'h0000_006F);

  state_t               st_q, st_d;
  logic [RCW-1:0]       rcnt_q, rcnt_d;
  logic [1:0]           cause_q, cause_d;
  logic                 skip_q, skip_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 clr;

  logic halt_instr;
  logic bp_hit;
  logic stop;

  assign halt_instr = (instr == I_ECALL) || (instr == I_EBREAK) ||
                      (instr == I_SELFJ);
  assign bp_hit     = bp_en && (pc == bp_addr) && !skip_q;
  assign stop       = halt_instr || bp_hit || halt_req;

  // Next-state, core controls and counter update.
  always_comb begin
    st_d    = st_q;
    rcnt_d  = rcnt_q;
    cause_d = cause_q;
    skip_d  = skip_q;
    cpu_rst = 1'b1;
    cpu_en  = 1'b0;
    clr     = 1'b0;
    case (st_q)
      S_IDLE: begin
        if (start) begin
          st_d    = S_RESET;
          rcnt_d  = RLOAD;
          cause_d = 2'd0;
          clr     = 1'b1;
        end
      end
      S_RESET: begin
        cpu_en = 1'b1;
        if (rcnt_q == '0) st_d = S_RUN;
        else rcnt_d = rcnt_q - 1'b1;
      end
      S_RUN: begin
        cpu_rst = 1'b0;
        cpu_en  = !stop;
        skip_d  = 1'b0;
        if (stop) begin
          st_d = S_HALT;
          if (halt_instr) cause_d = 2'd3;
          else if (bp_hit) cause_d = 2'd2;
          else cause_d = 2'd1;
        end
      end
      S_STEP: begin
        cpu_rst = 1'b0;
        cpu_en  = !halt_instr;
        st_d    = S_HALT;
        if (halt_instr) cause_d = 2'd3;
      end
      S_HALT: begin
        cpu_rst = 1'b0;
        if (start) begin
          st_d    = S_RESET;
          rcnt_d  = RLOAD;
          cause_d = 2'd0;
          clr     = 1'b1;
        end else if (step) begin
          st_d = S_STEP;
        end else if (resume) begin
          st_d   = S_RUN;
          skip_d = 1'b1;
        end
      end
      default: st_d = S_IDLE;
    endcase
    cnt_d = cnt_q;
    if (cpu_en && !cpu_rst && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    if (clr) cnt_d = '0;
  end

  // State and bookkeeping registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      st_q    <= S_IDLE;
      rcnt_q  <= '0;
      cause_q <= 2'd0;
      skip_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      st_q    <= st_d;
      rcnt_q  <= rcnt_d;
      cause_q <= cause_d;
      skip_q  <= skip_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state      = st_q;
  assign halted     = (st_q == S_HALT);
  assign halt_cause = cause_q;
  assign instret    = cnt_q;

endmodule
